// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump path.
// The register file and later debug blocks reuse the state encoding.
package regfile_pkg;

  // Register index width; fixed regardless of how many registers a bank holds
  localparam int REG_IDX_W = 5;

  // Bank select values as seen on rf_fpoint / out_fp
  localparam logic BANK_INT = 1'b0;
  localparam logic BANK_FP  = 1'b1;

  // Dump sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctr.sv
// Index/bank walker for the register-file dump.
// Steps through 0..NUM_REGS-1 of the integer bank, then of the FP bank,
// and flags the final (index, bank) pair of the dump.
module regfile_dump_ctr
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int INCLUDE_FP = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 advance,
  output logic [REG_IDX_W-1:0] index,
  output logic                 bank,
  output logic                 last
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(NUM_REGS - 1);
  localparam logic                 LAST_BANK = (INCLUDE_FP != 0) ? BANK_FP : BANK_INT;

  // Index/bank registers: clear back to int 0, or step with wrap into the FP bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index <= '0;
      bank  <= BANK_INT;
    end else if (clear) begin
      index <= '0;
      bank  <= BANK_INT;
    end else if (advance) begin
      if (index == LAST_IDX) begin
        index <= '0;
        bank  <= BANK_FP;
      end else begin
        index <= index + 1'b1;
      end
    end
  end

  // The dump ends on the top register of the last bank being walked
  always_comb begin
    last = (index == LAST_IDX) && (bank == LAST_BANK);
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Sequential register-file read-out engine.
// Takes over read port A on start, walks the integer bank (and optionally the
// FP bank), and streams each word out over a valid/ready interface.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int INCLUDE_FP = 1,
  parameter int DATA_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [REG_IDX_W-1:0] rf_rs,
  output logic                 rf_fpoint,
  input  logic [DATA_W-1:0]    rf_busA,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [REG_IDX_W-1:0] out_index,
  output logic                 out_fp,
  output logic                 out_last,
  output logic                 done
);

  dump_state_t state;
  dump_state_t state_next;

  logic ctr_clear;
  logic ctr_advance;
  logic ctr_last;
  logic capture;
  logic drop_valid;
  logic handshake;

  // The counter registers drive the register-file address directly, so the
  // read address is always a flop output.
  regfile_dump_ctr #(
    .NUM_REGS   (NUM_REGS),
    .INCLUDE_FP (INCLUDE_FP)
  ) u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (ctr_clear),
    .advance (ctr_advance),
    .index   (rf_rs),
    .bank    (rf_fpoint),
    .last    (ctr_last)
  );

  assign handshake = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode; abort overrides everything outside IDLE
  always_comb begin
    state_next  = state;
    ctr_clear   = 1'b0;
    ctr_advance = 1'b0;
    capture     = 1'b0;
    drop_valid  = 1'b0;
    case (state)
      IDLE: begin
        // Keeps the address parked at int 0 and primes the walk for start
        ctr_clear = 1'b1;
        if (start && !abort) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (abort) begin
          state_next = IDLE;
          ctr_clear  = 1'b1;
          drop_valid = 1'b1;
        end else begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (abort) begin
          state_next = IDLE;
          ctr_clear  = 1'b1;
          drop_valid = 1'b1;
        end else if (handshake) begin
          drop_valid = 1'b1;
          if (out_last) begin
            state_next = DONE;
          end else begin
            ctr_advance = 1'b1;
            state_next  = ADDR;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        ctr_clear  = 1'b1;
      end
      default: begin
        state_next = IDLE;
        ctr_clear  = 1'b1;
      end
    endcase
  end

  // Status outputs: busy tracks the upcoming state, done follows the DONE cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == DONE) && !abort;
    end
  end

  // Output word register: loads in ADDR, holds through HOLD until accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_fp    <= BANK_INT;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_last  <= ctr_last;
      out_data  <= rf_busA;
      out_index <= rf_rs;
      out_fp    <= rf_fpoint;
    end else if (drop_valid) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dump, back-pressure, restart
// and abort handling, mid-dump reset, and an integer-only small instance.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset_n;

  // Full-size instance (32 regs, FP bank included)
  logic        start, abort, out_ready;
  logic [4:0]  rf_rs;
  logic        rf_fpoint;
  logic [31:0] rf_busA;
  logic        busy, out_valid, out_fp, out_last, done;
  logic [31:0] out_data;
  logic [4:0]  out_index;

  // Small instance (4 regs, integer bank only)
  logic        start_s, abort_s, out_ready_s;
  logic [4:0]  rf_rs_s;
  logic        rf_fpoint_s;
  logic [31:0] rf_busA_s;
  logic        busy_s, out_valid_s, out_fp_s, out_last_s, done_s;
  logic [31:0] out_data_s;
  logic [4:0]  out_index_s;

  logic [31:0] int_rf [32];
  logic [31:0] fp_rf  [32];

  int n_tests = 0;
  int n_fail  = 0;
  int cnt, last_hs, done_c, n_done, n;
  logic fp_seen;
  logic [31:0] exp_data;
  logic [31:0] exp_tag;

  always #5 clk = ~clk;

  // Register file model: combinational read on port A
  assign rf_busA   = rf_fpoint   ? fp_rf[rf_rs]   : int_rf[rf_rs];
  assign rf_busA_s = rf_fpoint_s ? fp_rf[rf_rs_s] : int_rf[rf_rs_s];

  regfile_dump_reader #(.NUM_REGS(32), .INCLUDE_FP(1), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .rf_rs(rf_rs), .rf_fpoint(rf_fpoint), .rf_busA(rf_busA),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_fp(out_fp),
    .out_last(out_last), .done(done)
  );

  regfile_dump_reader #(.NUM_REGS(4), .INCLUDE_FP(0), .DATA_W(32)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start_s), .abort(abort_s),
    .rf_rs(rf_rs_s), .rf_fpoint(rf_fpoint_s), .rf_busA(rf_busA_s),
    .busy(busy_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_data(out_data_s), .out_index(out_index_s), .out_fp(out_fp_s),
    .out_last(out_last_s), .done(done_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the big instance presents the requested word (bounded)
  task automatic wait_word(input logic [4:0] idx, input logic fp, input string tag);
    int k;
    k = 0;
    while (!(out_valid && out_index == idx && out_fp == fp) && k < 300) begin
      tick();
      k++;
    end
    check(tag, 32'(k < 300), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      int_rf[i] = 32'(i + 100);
      fp_rf[i]  = 32'(i + 200);
    end
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_s = 1'b0; abort_s = 1'b0; out_ready_s = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rs",    32'(rf_rs), 32'd0);
    check("rst_fp",    32'(rf_fpoint), 32'd0);
    check("rst_data",  out_data, 32'd0);
    check("rst_done",  32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_rs",   32'(rf_rs), 32'd0);
    tick();
    check("sa_busy2",  32'(busy), 32'd0);
    check("sa_valid",  32'(out_valid), 32'd0);

    // Full dump with ready held high
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_addr", 32'(busy), 32'd1);
    cnt = 0; last_hs = -100; done_c = -1;
    for (int c = 0; c < 400; c++) begin
      if (out_valid && out_ready) begin
        exp_data = (cnt < 32) ? 32'(100 + cnt) : 32'(200 + cnt - 32);
        exp_tag  = 32'(cnt);
        check("t1_data", out_data, exp_data);
        check("t1_bank_idx", {26'd0, out_fp, out_index}, exp_tag);
        check("t1_last", 32'(out_last), 32'(cnt == 63));
        last_hs = c;
        cnt++;
      end
      if (done) begin
        done_c = c;
        break;
      end
      tick();
    end
    check("t1_count", 32'(cnt), 32'd64);
    check("t1_done_lat", 32'(done_c - last_hs), 32'd2);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    tick();
    check("t1_done_width", 32'(done), 32'd0);

    // Integer-only, 4-register instance
    out_ready_s = 1'b1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cnt = 0; fp_seen = 1'b0; n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (rf_fpoint_s) fp_seen = 1'b1;
      if (out_valid_s) begin
        check("s_data", out_data_s, 32'(100 + cnt));
        check("s_idx",  32'(out_index_s), 32'(cnt));
        check("s_fp",   32'(out_fp_s), 32'd0);
        check("s_last", 32'(out_last_s), 32'(cnt == 3));
        cnt++;
      end
      if (done_s) n_done++;
      tick();
    end
    check("s_count", 32'(cnt), 32'd4);
    check("s_fpoint_never", 32'(fp_seen), 32'd0);
    check("s_done_once", 32'(n_done), 32'd1);
    check("s_busy_end", 32'(busy_s), 32'd0);

    // Back-pressure on int 3
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_word(5'd3, 1'b0, "t2_reach3");
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_data",  out_data, 32'd103);
      check("t2_hold_idx",   32'(out_index), 32'd3);
    end
    out_ready = 1'b1;
    tick();
    check("t2_gap_valid", 32'(out_valid), 32'd0);
    tick();
    check("t2_next_valid", 32'(out_valid), 32'd1);
    check("t2_next_data",  out_data, 32'd104);
    check("t2_next_idx",   32'(out_index), 32'd4);

    // start while busy is ignored
    wait_word(5'd10, 1'b0, "t4_reach10");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy",  32'(busy), 32'd1);
    check("t4_rs",    32'(rf_rs), 32'd11);
    tick();
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_idx",   32'(out_index), 32'd11);
    check("t4_data",  out_data, 32'd111);

    // abort in HOLD at int 12
    wait_word(5'd12, 1'b0, "t4_reach12");
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_valid", 32'(out_valid), 32'd0);
    check("t4_abort_busy",  32'(busy), 32'd0);
    check("t4_abort_rs",    32'(rf_rs), 32'd0);
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) n_done++;
      tick();
    end
    check("t4_no_done", 32'(n_done), 32'd0);

    // Reset asserted during ADDR at fp 7
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(rf_fpoint && rf_rs == 5'd7) && n < 300) begin
      tick();
      n++;
    end
    check("t5_reach_fp7", 32'(n < 300), 32'd1);
    check("t5_in_addr", 32'(out_valid), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t5_busy",  32'(busy), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_last",  32'(out_last), 32'd0);
    check("t5_done",  32'(done), 32'd0);
    check("t5_rs",    32'(rf_rs), 32'd0);
    check("t5_fpt",   32'(rf_fpoint), 32'd0);
    check("t5_ofp",   32'(out_fp), 32'd0);
    check("t5_oidx",  32'(out_index), 32'd0);
    check("t5_data",  out_data, 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_re_busy", 32'(busy), 32'd1);
    check("t5_re_rs",   32'(rf_rs), 32'd0);
    check("t5_re_fpt",  32'(rf_fpoint), 32'd0);
    tick();
    check("t5_re_valid", 32'(out_valid), 32'd1);
    check("t5_re_idx",   32'(out_index), 32'd0);
    check("t5_re_fp",    32'(out_fp), 32'd0);
    check("t5_re_data",  out_data, 32'd100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
